// File: rtl/hex_digit_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : hex_digit_sequencer
//  Function : Decimal digit sequencer (0..9) with IDLE/RUN/PAUSE control,
//             prescaled count steps, edge-detected load/step requests and a
//             zero-latency seven-segment decode of the current digit.
//  Options  : COUNT_DOWN_EN - when defined, adds the dir port (1 = count down).
//  Revision : 1.0 - initial release
// ============================================================================
module hex_digit_sequencer #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [8:0] SW,
  input  logic       load,
  input  logic       step,
`ifdef COUNT_DOWN_EN
  input  logic       dir,
`endif
  output logic [3:0] digit,
  output logic [6:0] HEX0,
  output logic [1:0] state,
  output logic       wrap,
  output logic       load_err
);

  localparam int            PW           = $clog2(TICK_DIV);
  localparam logic [PW-1:0] C_PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] C_PRESC_ONE  = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_t;

  state_t        state_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    digit_q, digit_d;
  logic          wrap_q, wrap_d;
  logic          load_err_q, load_err_d;
  logic          load_q, step_q;

  logic          w_load_rise;
  logic          w_step_rise;
  logic          w_tick;
  logic          w_advance;
  logic          w_load_ok;
  logic          w_down;
  logic          w_adv_wrap;
  logic [3:0]    w_adv_digit;
  logic          w_unused_sw;

  // SW[7:4] carry no function
  assign w_unused_sw = ^SW[7:4];

`ifdef COUNT_DOWN_EN
  assign w_down = dir;
`else
  assign w_down = 1'b0;
`endif

  // Request edges, prescaler tick and the value one advance would produce
  always_comb begin
    w_load_rise = load & ~load_q;
    w_step_rise = step & ~step_q;
    w_tick      = (state_q == S_RUN) && (presc_q == C_PRESC_LAST);
    w_advance   = w_tick || (w_step_rise && (state_q == S_PAUSE));
    w_load_ok   = (SW[3:0] <= 4'd9);
    if (w_down) begin
      w_adv_wrap  = (digit_q == 4'd0);
      w_adv_digit = ((digit_q == 4'd0) || (digit_q > 4'd9)) ? 4'd9 : digit_q - 4'd1;
    end else begin
      w_adv_wrap  = (digit_q == 4'd9);
      w_adv_digit = (digit_q >= 4'd9) ? 4'd0 : digit_q + 4'd1;
    end
  end

  // Next digit/prescaler; a load edge (accepted or rejected) pre-empts tick and step
  always_comb begin
    presc_d    = presc_q;
    digit_d    = digit_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (w_load_rise) begin
      if (w_load_ok) begin
        digit_d = SW[3:0];
        presc_d = '0;
      end else begin
        load_err_d = 1'b1;
      end
    end else begin
      case (state_q)
        S_RUN:   presc_d = w_tick ? '0 : presc_q + C_PRESC_ONE;
        S_PAUSE: presc_d = presc_q;
        default: presc_d = '0;
      endcase
      if (w_advance) begin
        digit_d = w_adv_digit;
        wrap_d  = w_adv_wrap;
      end
    end
  end

  // Control FSM plus all registered state and outputs
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      digit_q    <= 4'd0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
      load_q     <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      load_q     <= load;
      step_q     <= step;
      presc_q    <= presc_d;
      digit_q    <= digit_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
      case (state_q)
        S_IDLE:  if (SW[8])  state_q <= S_RUN;
        S_RUN:   if (!SW[8]) state_q <= S_PAUSE;
        S_PAUSE: if (SW[8])  state_q <= S_RUN;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Seven-segment decode, bit 0 = segment a
  always_comb begin
    case (digit_q)
      4'd0:    HEX0 = 7'b0111111;
      4'd1:    HEX0 = 7'b0000110;
      4'd2:    HEX0 = 7'b1011011;
      4'd3:    HEX0 = 7'b1001111;
      4'd4:    HEX0 = 7'b1100110;
      4'd5:    HEX0 = 7'b1101101;
      4'd6:    HEX0 = 7'b1111101;
      4'd7:    HEX0 = 7'b0000111;
      4'd8:    HEX0 = 7'b1111111;
      4'd9:    HEX0 = 7'b1101111;
      default: HEX0 = 7'b0000000;
    endcase
  end

  assign digit    = digit_q;
  assign state    = state_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_digit_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hex_digit_sequencer
//  Function : Directed self-checking bench for hex_digit_sequencer, TICK_DIV=4.
//             Down-count checks are compiled when COUNT_DOWN_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hex_digit_sequencer;

  logic       CLOCK_50;
  logic       reset;
  logic [8:0] SW;
  logic       load;
  logic       step;
`ifdef COUNT_DOWN_EN
  logic       dir;
`endif
  logic [3:0] digit;
  logic [6:0] HEX0;
  logic [1:0] state;
  logic       wrap;
  logic       load_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seg_tbl [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                               7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                               7'b1111111, 7'b1101111};

  hex_digit_sequencer #(.TICK_DIV(4)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .SW       (SW),
    .load     (load),
    .step     (step),
`ifdef COUNT_DOWN_EN
    .dir      (dir),
`endif
    .digit    (digit),
    .HEX0     (HEX0),
    .state    (state),
    .wrap     (wrap),
    .load_err (load_err)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance n rising edges, then settle 1 time unit past the edge
  task automatic clk(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    SW    = 9'h000;
    load  = 1'b0;
    step  = 1'b0;
`ifdef COUNT_DOWN_EN
    dir   = 1'b0;
`endif
    clk(2);
    chk("rst_digit", digit, 0);
    chk("rst_hex", HEX0, 7'b0111111);
    chk("rst_state", state, 2'b00);
    chk("rst_wrap", wrap, 0);
    chk("rst_lerr", load_err, 0);

    // step edge in IDLE is ignored
    reset = 1'b0;
    step  = 1'b1;
    clk(1);
    chk("idle_step_state", state, 2'b00);
    chk("idle_step_digit", digit, 0);
    step = 1'b0;

    // run for 40 cycles: one advance every 4, single wrap on 9->0
    SW = 9'h100;
    clk(1);
    chk("run_enter_state", state, 2'b01);
    chk("run_enter_digit", digit, 0);
    for (int c = 1; c <= 40; c++) begin
      clk(1);
      chk("run_digit", digit, (c / 4) % 10);
      chk("run_wrap", wrap, (c == 40));
      if (c % 4 == 0) chk("run_hex", HEX0, seg_tbl[(c / 4) % 10]);
    end
    chk("run_state", state, 2'b01);

    // load 7 mid-period in RUN: prescaler restarts
    clk(2);
    SW   = 9'h107;
    load = 1'b1;
    clk(1);
    chk("load7_digit", digit, 7);
    chk("load7_hex", HEX0, 7'b0000111);
    chk("load7_wrap", wrap, 0);
    load = 1'b0;
    clk(3);
    chk("load7_hold", digit, 7);
    clk(1);
    chk("load7_next", digit, 8);

    // load 3 coincident with a tick: load wins, no wrap
    clk(3);
    chk("pre_coinc_digit", digit, 8);
    SW   = 9'h103;
    load = 1'b1;
    clk(1);
    chk("coinc_digit", digit, 3);
    chk("coinc_wrap", wrap, 0);
    chk("coinc_lerr", load_err, 0);
    load = 1'b0;
    clk(3);
    chk("coinc_hold", digit, 3);
    clk(1);
    chk("coinc_next", digit, 4);

    // count to 9 and pause
    clk(20);
    chk("to9_digit", digit, 9);
    SW = 9'h000;
    clk(1);
    chk("pause_state", state, 2'b10);
    chk("pause_digit", digit, 9);

    // rejected load (12) while paused; load held high gives a single pulse
    SW   = 9'h00C;
    load = 1'b1;
    clk(1);
    chk("lerr_pulse", load_err, 1);
    chk("lerr_digit", digit, 9);
    clk(1);
    chk("lerr_drop", load_err, 0);
    chk("lerr_digit2", digit, 9);
    load = 1'b0;

    // step held 3 cycles in PAUSE: one advance 9->0 with one wrap
    step = 1'b1;
    clk(1);
    chk("step_digit", digit, 0);
    chk("step_wrap", wrap, 1);
    chk("step_state", state, 2'b10);
    clk(1);
    chk("step_wrap2", wrap, 0);
    clk(1);
    chk("step_digit3", digit, 0);
    chk("step_wrap3", wrap, 0);
    step = 1'b0;

    // resume: prescaler kept its value (1) across PAUSE
    SW = 9'h100;
    clk(1);
    chk("resume_state", state, 2'b01);
    clk(2);
    chk("resume_hold", digit, 0);
    clk(1);
    chk("resume_adv", digit, 1);

    // reset mid-count discards prescaler progress
    clk(2);
    reset = 1'b1;
    clk(1);
    chk("mid_rst_digit", digit, 0);
    chk("mid_rst_state", state, 2'b00);
    chk("mid_rst_hex", HEX0, 7'b0111111);
    reset = 1'b0;
    clk(1);
    chk("post_rst_state", state, 2'b01);
    clk(3);
    chk("post_rst_hold", digit, 0);
    clk(1);
    chk("post_rst_adv", digit, 1);

`ifdef COUNT_DOWN_EN
    // down count from 0: 9 with wrap, then 8; then reset mid-count
    reset = 1'b1;
    dir   = 1'b1;
    SW    = 9'h100;
    clk(1);
    reset = 1'b0;
    clk(1);
    chk("dn_state", state, 2'b01);
    clk(4);
    chk("dn_digit9", digit, 9);
    chk("dn_wrap", wrap, 1);
    clk(4);
    chk("dn_digit8", digit, 8);
    chk("dn_wrap2", wrap, 0);
    clk(2);
    reset = 1'b1;
    clk(1);
    chk("dn_rst_digit", digit, 0);
    chk("dn_rst_state", state, 2'b00);
    reset = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hex_digit_sequencer.md
HEX_DIGIT_SEQUENCER -- requirements
Module: hex_digit_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 50000000, CLOCK_50 cycles per count step; legal range 2..2^26.
REQ-002 CLOCK_50  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 SW  input  9  SW[3:0] = load value; SW[8] = run enable (1 = count); SW[7:4] unused.
REQ-005 load  input  1  level input; a 0->1 transition requests a load of SW[3:0].
REQ-006 step  input  1  level input; a 0->1 transition requests a single advance while paused.
REQ-007 dir  input  1  count direction, 0 = up, 1 = down; present only when COUNT_DOWN_EN is defined.
REQ-008 digit  output  4  current digit value, always within 0..9.
REQ-009 HEX0  output  7  segment pattern for digit, active-high segments, bit 0 = segment a.
REQ-010 state  output  2  FSM state code: 00 IDLE, 01 RUN, 10 PAUSE.
REQ-011 wrap  output  1  one-cycle pulse on wrap-around.
REQ-012 load_err  output  1  one-cycle pulse on a rejected load.

Function
REQ-013 load and step shall each be edge-detected against a registered copy of the previous cycle's value; one edge yields exactly one action.
REQ-014 FSM: IDLE->RUN when SW[8]=1; RUN->PAUSE when SW[8]=0; PAUSE->RUN when SW[8]=1; no transition returns to IDLE except reset.
REQ-015 Prescaler shall count 0..TICK_DIV-1 in RUN only and assert an internal tick in the cycle it equals TICK_DIV-1, then return to 0.
REQ-016 In PAUSE the prescaler shall hold its value; in IDLE it shall stay 0.
REQ-017 On tick, digit shall advance by one: up 9->0, down 0->9; other values +1/-1.
REQ-018 Advancing 9->0 (up) or 0->9 (down) shall pulse wrap in the cycle digit takes the new value.
REQ-019 A step edge in PAUSE shall advance digit exactly as a tick does, including wrap; step edges in IDLE or RUN shall be ignored.
REQ-020 A load edge with SW[3:0] <= 9 shall set digit to SW[3:0] next cycle and clear the prescaler, in any state; the FSM state is unchanged.
REQ-021 A load edge with SW[3:0] > 9 shall leave digit and prescaler unchanged and pulse load_err for one cycle.
REQ-022 Load has priority over tick and step in the same cycle; no wrap pulse results from a load.
REQ-023 HEX0 shall be a combinational decode of digit, zero latency: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
REQ-024 Any digit encoding outside 0..9 (unreachable) shall decode to 0000000.

Reset
REQ-025 reset shall override all inputs in the cycle it is sampled high.
REQ-026 Reset values: state=IDLE, digit=0, HEX0=0111111, prescaler=0, wrap=0, load_err=0, edge-detect registers=0.
REQ-027 reset asserted mid-count shall discard prescaler progress; after release, counting resumes only via IDLE->RUN.

Configuration
REQ-028 Macro COUNT_DOWN_EN: when defined, the dir port exists and selects direction per REQ-017/018, sampled on the tick/step cycle.
REQ-029 When COUNT_DOWN_EN is undefined, the dir port is absent and counting is up-only; all other behaviour is identical.

Verification (TICK_DIV=4)
REQ-030 Reset, SW[8]=1 for 40 cycles -> digit advances 0..9 every 4 cycles, wrap pulses once on 9->0, state=01.
REQ-031 SW[3:0]=7, load edge while in RUN -> digit=7, HEX0=0000111, prescaler=0, next advance 4 cycles later.
REQ-032 SW[3:0]=12, load edge -> digit unchanged, load_err high exactly 1 cycle.
REQ-033 SW[8]=0 at digit=9, then step held high 3 cycles -> exactly one advance to 0, one wrap pulse, state=10.
REQ-034 Load edge and tick in the same cycle with SW[3:0]=3 -> digit=3, no wrap, prescaler=0.
REQ-035 COUNT_DOWN_EN defined, dir=1, RUN from digit=0 -> digit 9 after one tick with wrap, then 8; reset mid-count -> digit=0, state=00.
